tdc_ctrl: RTL and testbench

//  Sequencer for one 32-bit cascaded TDC in the time-domain MAC. Per request: clears the TDC, launches the

---
 rtl/tdc_ctrl_pkg.sv | 29 ++
 rtl/tdc_ctrl_timer.sv | 34 +++
 rtl/tdc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tdc_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_ctrl_pkg.sv
// ============================================================================
// tdc_ctrl_pkg : shared state encoding and default timing for the TDC sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package tdc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLR     = 3'd1,
      ARM     = 3'd2,
      SETTLE  = 3'd3,
      CAPTURE = 3'd4,
      HOLD    = 3'd5,
      CAL     = 3'd6
   } state_t;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_CLR_CYC    = 2;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_CNT_W      = 8;

   // Raw code reported when the start edge outran the whole cascade window
   localparam logic [DEF_WIDTH-1:0] SAT_CODE = {DEF_WIDTH{1'b1}};

endpackage

`default_nettype wire

// File: rtl/tdc_ctrl_timer.sv
// ============================================================================
// tdc_ctrl_timer : loadable down-counter that times the CLR and SETTLE phases
// Rev 1.0
// ============================================================================
`default_nettype none

module tdc_ctrl_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tdc_ctrl.sv
// ============================================================================
// tdc_ctrl : clear/launch/settle/capture sequencer for one cascaded TDC.
// Optional zero-offset calibration enabled by defining TDC_CTRL_ZERO_CAL_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module tdc_ctrl
   import tdc_ctrl_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int CLR_CYC    = DEF_CLR_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   output logic             tdc_rst,
   output logic             tdc_start,
   input  logic [WIDTH-1:0] tdc_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_sat,
   output logic             busy
`ifdef TDC_CTRL_ZERO_CAL_EN
   ,
   input  logic             cal_req
`endif
);

   // CLR is entered with the timer already loaded, so it needs one less count
   localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
   localparam logic [WIDTH-1:0] SAT         = {WIDTH{1'b1}};

   state_t           state;
   logic             cal_mode;
   logic             accept;
   logic             cal_go;
   logic             tmr_load;
   logic             tmr_dec;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic [WIDTH-1:0] corr;

`ifdef TDC_CTRL_ZERO_CAL_EN
   logic [WIDTH-1:0] ofs;

   assign cal_go = cal_req & req_ready;
   assign corr   = (tdc_out >= ofs) ? (tdc_out - ofs) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ofs <= '0;
      end else if (state == CAL) begin
         ofs <= tdc_out;
      end
   end
`else
   assign cal_go = 1'b0;
   assign corr   = tdc_out;
`endif

   // Calibration wins when both requests arrive together
   assign accept = req_valid & req_ready & ~cal_go;

   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = CLR_LOAD;
      case (state)
         IDLE:    tmr_load = accept | cal_go;
         ARM: begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
         end
         CLR,
         SETTLE:  tmr_dec  = 1'b1;
         default: tmr_load = 1'b0;
      endcase
   end

   tdc_ctrl_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cal_mode  <= 1'b0;
         req_ready <= 1'b0;
         tdc_rst   <= 1'b0;
         tdc_start <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_sat   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tdc_start <= 1'b0;
               if (cal_go || accept) begin
                  state     <= CLR;
                  cal_mode  <= cal_go;
                  req_ready <= 1'b0;
                  tdc_rst   <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  req_ready <= 1'b1;
                  tdc_rst   <= 1'b1;
               end
            end
            CLR: begin
               if (tmr_zero) begin
                  state     <= ARM;
                  tdc_rst   <= 1'b1;
                  tdc_start <= 1'b1;
               end
            end
            ARM: begin
               state <= SETTLE;
            end
            SETTLE: begin
               if (tmr_zero) begin
                  state     <= cal_mode ? CAL : CAPTURE;
                  tdc_start <= 1'b0;
               end
            end
            CAPTURE: begin
               state     <= HOLD;
               res_data  <= corr;
               res_sat   <= (tdc_out == SAT);
               res_valid <= 1'b1;
            end
            HOLD: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            CAL: begin
               state     <= IDLE;
               cal_mode  <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               tdc_rst   <= 1'b1;
               tdc_start <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tdc_ctrl.sv
// ============================================================================
// tb_tdc_ctrl : directed self-checking bench for tdc_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tdc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        tdc_rst;
   logic        tdc_start;
   logic [31:0] tdc_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_sat;
   logic        busy;
`ifdef TDC_CTRL_ZERO_CAL_EN
   logic        cal_req;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tdc_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .tdc_rst   (tdc_rst),
      .tdc_start (tdc_start),
      .tdc_out   (tdc_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_sat   (res_sat),
      .busy      (busy)
`ifdef TDC_CTRL_ZERO_CAL_EN
      ,
      .cal_req   (cal_req)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request from IDLE; result held for hold_cyc cycles before res_ready
   task automatic run_conv(input string tag, input logic [31:0] code,
                           input logic [31:0] exp_data, input logic exp_sat,
                           input int hold_cyc);
      int   lat;
      int   low;
      int   hi;
      int   unstable;
      logic rdy_seen;
      check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
      tdc_out   = code;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      lat = 0; low = 0; hi = 0; rdy_seen = 1'b0;
      while (!res_valid && lat < 40) begin
         if (!tdc_rst)  low++;
         if (tdc_start) hi++;
         if (req_ready) rdy_seen = 1'b1;
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd13);
      check({tag, "_tdc_rst_low"}, 64'(low), 64'd2);
      check({tag, "_tdc_start_hi"}, 64'(hi), 64'd10);
      check({tag, "_ready_busy"}, 64'(rdy_seen), 64'd0);
      check({tag, "_data"}, 64'(res_data), 64'(exp_data));
      check({tag, "_sat"}, 64'(res_sat), 64'(exp_sat));
      // The TDC code changes after capture; the result must not follow it
      tdc_out  = ~code;
      unstable = 0;
      for (int i = 0; i < hold_cyc; i++) begin
         step();
         if (!res_valid || res_data !== exp_data || req_ready || !busy) unstable++;
      end
      if (hold_cyc > 0) check({tag, "_hold_stable"}, 64'(unstable), 64'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
      check({tag, "_busy_clr"}, 64'(busy), 64'd0);
      check({tag, "_data_kept"}, 64'(res_data), 64'(exp_data));
   endtask

   initial begin
      int   n;
      logic seen;

      rst       = 1'b0;
      req_valid = 1'b1;
      res_ready = 1'b0;
      tdc_out   = 32'h0;
`ifdef TDC_CTRL_ZERO_CAL_EN
      cal_req   = 1'b0;
`endif

      // Reset held two cycles with a request pending
      step();
      step();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_tdc_rst", 64'(tdc_rst), 64'd0);
      check("rst_tdc_start", 64'(tdc_start), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data", 64'(res_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst       = 1'b1;
      req_valid = 1'b0;
      step();
      check("rel_req_ready", 64'(req_ready), 64'd1);
      check("rel_tdc_rst", 64'(tdc_rst), 64'd1);

      // Single conversion, then 20 cycles of backpressure
      run_conv("conv", 32'h0000_1234, 32'h0000_1234, 1'b0, 0);
      step();
      run_conv("bp", 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 20);

      // Saturation boundary
      run_conv("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
      run_conv("nearsat", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 0);

      // Reset in the middle of SETTLE aborts without a result
      tdc_out   = 32'h5555;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("abort_pre_start", 64'(tdc_start), 64'd1);
      rst = 1'b0;
      step();
      check("abort_tdc_start", 64'(tdc_start), 64'd0);
      check("abort_tdc_rst", 64'(tdc_rst), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      rst  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (res_valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'd0);
      run_conv("post_abort", 32'h0000_ABCD, 32'h0000_ABCD, 1'b0, 0);

`ifdef TDC_CTRL_ZERO_CAL_EN
      // Calibration wins over a simultaneous request and yields no result
      tdc_out   = 32'h10;
      cal_req   = 1'b1;
      req_valid = 1'b1;
      step();
      cal_req   = 1'b0;
      req_valid = 1'b0;
      check("cal_busy", 64'(busy), 64'd1);
      n    = 0;
      seen = 1'b0;
      while (busy && n < 40) begin
         if (res_valid) seen = 1'b1;
         step();
         n++;
      end
      check("cal_duration", 64'(n), 64'd13);
      check("cal_no_valid", 64'(seen), 64'd0);
      run_conv("cal_sub", 32'h30, 32'h20, 1'b0, 0);
      run_conv("cal_floor", 32'h08, 32'h0, 1'b0, 0);
      run_conv("cal_equal", 32'h10, 32'h0, 1'b0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
